// File: rtl/agc_gain_control_pkg.sv
// Shared definitions for the AGC gain loop: FSM state encodings, gain
// limits and the reset gain.
package agc_gain_control_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COMPARE = 2'd1,
        ST_UPDATE  = 2'd2,
        ST_SETTLE  = 2'd3
    } agc_state_e;

    localparam int unsigned GAIN_MIN   = 32'd1;
    localparam int unsigned GAIN_RESET = 32'd1;

    // Largest gain representable in a w-bit unsigned register.
    function automatic int unsigned gain_max(input int unsigned w);
        return (32'd1 << w) - 32'd1;
    endfunction

endpackage

// File: rtl/agc_gain_control_mult.sv
// agc_gain_mult: two-stage I/Q register-and-multiply pipeline.
// Stage 1 captures samples on valid and holds otherwise; stage 2 forms the
// full-width unsigned product with the gain sampled once per cycle.
module agc_gain_mult #(
    parameter int W_IN   = 16,
    parameter int W_GAIN = 10
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [W_IN-1:0]          in_i,
    input  logic [W_IN-1:0]          in_q,
    input  logic                     in_valid,
    input  logic [W_GAIN-1:0]        gain,
    output logic [W_IN+W_GAIN-1:0]   out_i,
    output logic [W_IN+W_GAIN-1:0]   out_q,
    output logic                     out_valid
);

    localparam int W_OUT = W_IN + W_GAIN;

    logic [W_IN-1:0] s1_i_r;
    logic [W_IN-1:0] s1_q_r;
    logic            s1_valid_r;

    // Stage 1: capture samples when qualified, hold otherwise; valid delays independently.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_i_r     <= {W_IN{1'b0}};
            s1_q_r     <= {W_IN{1'b0}};
            s1_valid_r <= 1'b0;
        end else begin
            s1_valid_r <= in_valid;
            if (in_valid) begin
                s1_i_r <= in_i;
                s1_q_r <= in_q;
            end else begin
                s1_i_r <= s1_i_r;
                s1_q_r <= s1_q_r;
            end
        end
    end

    // Stage 2: full-width products using the gain present this cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_i     <= {W_OUT{1'b0}};
            out_q     <= {W_OUT{1'b0}};
            out_valid <= 1'b0;
        end else begin
            out_i     <= {{W_GAIN{1'b0}}, s1_i_r} * {{W_IN{1'b0}}, gain};
            out_q     <= {{W_GAIN{1'b0}}, s1_q_r} * {{W_IN{1'b0}}, gain};
            out_valid <= s1_valid_r;
        end
    end

endmodule

// File: rtl/agc_gain_control.sv
// agc_gain_control: closes the AGC loop. Compares the smoothed level with a
// target window, steps the gain, and applies it to the I/Q stream.
// Optional build macro AGC_FREEZE_EN adds an agc_freeze input that parks the
// loop in IDLE and holds gain/locked while asserted.
module agc_gain_control
    import agc_gain_control_pkg::*;
#(
    parameter int W_IN       = 16,
    parameter int W_GAIN     = 10,
    parameter int W_LVL      = 48,
    parameter int GAIN_STEP  = 1,
    parameter int SETTLE_CNT = 16,
    parameter int LOCK_CNT   = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [W_LVL-1:0]        level_in,
    input  logic                    level_valid,
    input  logic [W_LVL-1:0]        target_level,
    input  logic [W_LVL-1:0]        hysteresis,
    input  logic [W_IN-1:0]         s_chans_dataI,
    input  logic [W_IN-1:0]         s_chans_dataQ,
    input  logic                    s_chans_valid,
    output logic [W_IN+W_GAIN-1:0]  m_dataI,
    output logic [W_IN+W_GAIN-1:0]  m_dataQ,
    output logic                    m_valid,
    output logic [W_GAIN-1:0]       gain_out,
    output logic                    locked
`ifdef AGC_FREEZE_EN
    ,
    input  logic                    agc_freeze
`endif
);

    localparam int LOCK_W   = $clog2(LOCK_CNT + 1);
    localparam int SETTLE_W = $clog2(SETTLE_CNT + 1);

    localparam logic [W_GAIN:0]     GAIN_MIN_X  = (W_GAIN+1)'(GAIN_MIN);
    localparam logic [W_GAIN:0]     GAIN_MAX_X  = (W_GAIN+1)'(gain_max(W_GAIN));
    localparam logic [W_GAIN:0]     GAIN_STEP_X = (W_GAIN+1)'(GAIN_STEP);
    localparam logic [W_GAIN-1:0]   GAIN_RST    = W_GAIN'(GAIN_RESET);
    localparam logic [LOCK_W-1:0]   LOCK_MAX    = LOCK_W'(LOCK_CNT);
    localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_CNT - 1);

    agc_state_e           state_r;
    logic [W_LVL-1:0]     level_r;
    logic [W_LVL:0]       hi_r;
    logic [W_LVL-1:0]     lo_r;
    logic [W_GAIN-1:0]    gain_r;
    logic [LOCK_W-1:0]    lock_cnt_r;
    logic [SETTLE_W-1:0]  settle_cnt_r;
    logic                 locked_r;

    logic                 freeze_s;
    logic [W_GAIN:0]      gain_x_s;
    logic [W_GAIN:0]      gain_up_s;
    logic [W_GAIN:0]      gain_dn_s;
    logic [W_GAIN:0]      upd_gain_x_s;
    logic [W_GAIN-1:0]    upd_gain_s;
    logic [LOCK_W-1:0]    upd_lock_cnt_s;
    logic                 upd_locked_s;
    logic                 upd_changed_s;
    logic                 above_s;
    logic                 below_s;

`ifdef AGC_FREEZE_EN
    assign freeze_s = agc_freeze;
`else
    assign freeze_s = 1'b0;
`endif

    assign gain_x_s = {1'b0, gain_r};
    assign above_s  = {1'b0, level_r} > hi_r;
    assign below_s  = level_r < lo_r;

    // Saturating up/down gain candidates, computed one bit wider to avoid wrap.
    always_comb begin
        gain_up_s = gain_x_s + GAIN_STEP_X;
        if (gain_up_s > GAIN_MAX_X) begin
            gain_up_s = GAIN_MAX_X;
        end else begin
            gain_up_s = gain_up_s;
        end
        if (gain_x_s < (GAIN_MIN_X + GAIN_STEP_X)) begin
            gain_dn_s = GAIN_MIN_X;
        end else begin
            gain_dn_s = gain_x_s - GAIN_STEP_X;
        end
    end

    // Window decision applied in UPDATE: next gain, lock counter and lock flag.
    always_comb begin
        upd_gain_x_s   = gain_x_s;
        upd_lock_cnt_s = lock_cnt_r;
        upd_locked_s   = locked_r;
        if (above_s) begin
            upd_gain_x_s   = gain_dn_s;
            upd_lock_cnt_s = {LOCK_W{1'b0}};
            upd_locked_s   = 1'b0;
        end else if (below_s) begin
            upd_gain_x_s   = gain_up_s;
            upd_lock_cnt_s = {LOCK_W{1'b0}};
            upd_locked_s   = 1'b0;
        end else begin
            if (lock_cnt_r < LOCK_MAX) begin
                upd_lock_cnt_s = lock_cnt_r + LOCK_W'(1);
            end else begin
                upd_lock_cnt_s = LOCK_MAX;
            end
            upd_locked_s = (upd_lock_cnt_s == LOCK_MAX);
        end
        upd_gain_s    = upd_gain_x_s[W_GAIN-1:0];
        upd_changed_s = (upd_gain_s != gain_r);
    end

    // Loop FSM with gain, lock and settle bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            level_r      <= {W_LVL{1'b0}};
            hi_r         <= {(W_LVL+1){1'b0}};
            lo_r         <= {W_LVL{1'b0}};
            gain_r       <= GAIN_RST;
            lock_cnt_r   <= {LOCK_W{1'b0}};
            settle_cnt_r <= {SETTLE_W{1'b0}};
            locked_r     <= 1'b0;
        end else if (freeze_s) begin
            state_r      <= ST_IDLE;
            lock_cnt_r   <= {LOCK_W{1'b0}};
            settle_cnt_r <= {SETTLE_W{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (level_valid) begin
                        level_r <= level_in;
                        state_r <= ST_COMPARE;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_COMPARE: begin
                    hi_r <= {1'b0, target_level} + {1'b0, hysteresis};
                    if (target_level > hysteresis) begin
                        lo_r <= target_level - hysteresis;
                    end else begin
                        lo_r <= {W_LVL{1'b0}};
                    end
                    state_r <= ST_UPDATE;
                end
                ST_UPDATE: begin
                    gain_r     <= upd_gain_s;
                    lock_cnt_r <= upd_lock_cnt_s;
                    locked_r   <= upd_locked_s;
                    if (upd_changed_s) begin
                        state_r <= ST_SETTLE;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_SETTLE: begin
                    if (level_valid) begin
                        if (settle_cnt_r == SETTLE_LAST) begin
                            settle_cnt_r <= {SETTLE_W{1'b0}};
                            state_r      <= ST_IDLE;
                        end else begin
                            settle_cnt_r <= settle_cnt_r + SETTLE_W'(1);
                        end
                    end else begin
                        settle_cnt_r <= settle_cnt_r;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign gain_out = gain_r;
    assign locked   = locked_r;

    agc_gain_mult #(
        .W_IN   (W_IN),
        .W_GAIN (W_GAIN)
    ) u_mult (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_i      (s_chans_dataI),
        .in_q      (s_chans_dataQ),
        .in_valid  (s_chans_valid),
        .gain      (gain_r),
        .out_i     (m_dataI),
        .out_q     (m_dataQ),
        .out_valid (m_valid)
    );

endmodule

// File: tb/tb_agc_gain_control.sv
// Testbench for agc_gain_control: randomized level/sample stimulus checked
// against a transaction-level model of the gain loop.
module tb_agc_gain_control;

    localparam int W_IN       = 16;
    localparam int W_GAIN     = 10;
    localparam int W_LVL      = 48;
    localparam int SETTLE_CNT = 16;
    localparam int LOCK_CNT   = 8;
    localparam int GMAX       = 1023;
    localparam longint unsigned LVL_MAX = (64'd1 << W_LVL) - 64'd1;

    logic                    clk;
    logic                    rst_n;
    logic [W_LVL-1:0]        level_in;
    logic                    level_valid;
    logic [W_LVL-1:0]        target_level;
    logic [W_LVL-1:0]        hysteresis;
    logic [W_IN-1:0]         s_chans_dataI;
    logic [W_IN-1:0]         s_chans_dataQ;
    logic                    s_chans_valid;
    logic [W_IN+W_GAIN-1:0]  m_dataI;
    logic [W_IN+W_GAIN-1:0]  m_dataQ;
    logic                    m_valid;
    logic [W_GAIN-1:0]       gain_out;
    logic                    locked;
    logic                    agc_freeze;

    int n_checks;
    int n_errs;

    // Reference model state
    int              m_gain;
    int              m_locked;
    int              m_lock_cnt;
    int              m_settle;
    longint unsigned cur_target;
    longint unsigned cur_hyst;

    agc_gain_control dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .level_in      (level_in),
        .level_valid   (level_valid),
        .target_level  (target_level),
        .hysteresis    (hysteresis),
        .s_chans_dataI (s_chans_dataI),
        .s_chans_dataQ (s_chans_dataQ),
        .s_chans_valid (s_chans_valid),
        .m_dataI       (m_dataI),
        .m_dataQ       (m_dataQ),
        .m_valid       (m_valid),
        .gain_out      (gain_out),
        .locked        (locked)
`ifdef AGC_FREEZE_EN
        ,
        .agc_freeze    (agc_freeze)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_gain = 1; m_locked = 0; m_lock_cnt = 0; m_settle = 0;
    endtask

    // One accepted level report: either swallowed by settling or a loop decision.
    task automatic model_pulse(input longint unsigned lvl);
        longint unsigned hi, lo;
        int ng;
        if (m_settle > 0) begin
            m_settle--;
            return;
        end
        hi = cur_target + cur_hyst;
        lo = (cur_target > cur_hyst) ? cur_target - cur_hyst : 64'd0;
        ng = m_gain;
        if (lvl > hi) begin
            ng = (m_gain > 1) ? m_gain - 1 : 1;
            m_lock_cnt = 0; m_locked = 0;
        end else if (lvl < lo) begin
            ng = (m_gain < GMAX) ? m_gain + 1 : GMAX;
            m_lock_cnt = 0; m_locked = 0;
        end else begin
            if (m_lock_cnt < LOCK_CNT) m_lock_cnt++;
            m_locked = (m_lock_cnt == LOCK_CNT) ? 1 : 0;
        end
        if (ng != m_gain) m_settle = SETTLE_CNT;
        m_gain = ng;
    endtask

    task automatic set_window(input longint unsigned t, input longint unsigned h);
        @(negedge clk);
        target_level = W_LVL'(t);
        hysteresis   = W_LVL'(h);
        cur_target   = t;
        cur_hyst     = h;
    endtask

    task automatic check_loop(input string tag);
        check_eq({tag, "_gain"}, 64'(gain_out), 64'(m_gain));
        check_eq({tag, "_locked"}, 64'(locked), 64'(m_locked));
    endtask

    // Single level_valid pulse; waits long enough for a decision when not settling.
    task automatic pulse(input longint unsigned lvl, input string tag);
        int gap;
        gap = (m_settle > 0) ? 0 : 3;
        @(negedge clk);
        level_in    = W_LVL'(lvl);
        level_valid = 1'b1;
        @(negedge clk);
        level_valid = 1'b0;
        model_pulse(lvl);
        repeat (gap) @(negedge clk);
        check_loop(tag);
    endtask

    // Two back-to-back pulses; the second lands in COMPARE and must be dropped.
    task automatic double_pulse(input longint unsigned lvl, input string tag);
        @(negedge clk);
        level_in    = W_LVL'(lvl);
        level_valid = 1'b1;
        @(negedge clk);
        level_in    = (lvl > 64'd0) ? W_LVL'(64'd0) : W_LVL'(LVL_MAX);
        @(negedge clk);
        level_valid = 1'b0;
        model_pulse(lvl);
        repeat (2) @(negedge clk);
        check_loop(tag);
    endtask

    task automatic drain_settle();
        while (m_settle > 0) pulse(64'($urandom), "settle");
    endtask

    // Push one I/Q sample and check the scaled output two cycles later.
    task automatic drive_iq(input int i, input int q, input string tag);
        longint unsigned ei, eq;
        @(negedge clk);
        s_chans_dataI = W_IN'(i);
        s_chans_dataQ = W_IN'(q);
        s_chans_valid = 1'b1;
        @(negedge clk);
        s_chans_valid = 1'b0;
        check_eq({tag, "_mvalid_early"}, 64'(m_valid), 64'd0);
        @(negedge clk);
        ei = longint'(i) * longint'(m_gain);
        eq = longint'(q) * longint'(m_gain);
        check_eq({tag, "_mvalid"}, 64'(m_valid), 64'd1);
        check_eq({tag, "_mI"}, 64'(m_dataI), ei);
        check_eq({tag, "_mQ"}, 64'(m_dataQ), eq);
        @(negedge clk);
        check_eq({tag, "_mvalid_drop"}, 64'(m_valid), 64'd0);
        check_eq({tag, "_mI_hold"}, 64'(m_dataI), ei);
    endtask

    initial begin
        longint unsigned lvl, hi, lo, d;
        n_checks = 0; n_errs = 0;
        rst_n = 1'b0; level_in = '0; level_valid = 1'b0;
        target_level = '0; hysteresis = '0;
        s_chans_dataI = '0; s_chans_dataQ = '0; s_chans_valid = 1'b0;
        agc_freeze = 1'b0;
        cur_target = 0; cur_hyst = 0;
        model_reset();

        // Reset state
        repeat (3) @(negedge clk);
        check_eq("rst_gain", 64'(gain_out), 64'd1);
        check_eq("rst_locked", 64'(locked), 64'd0);
        check_eq("rst_mvalid", 64'(m_valid), 64'd0);
        check_eq("rst_mI", 64'(m_dataI), 64'd0);
        rst_n = 1'b1;
        drive_iq(100, 100, "rst_iq");
        check_loop("rst_loop");

`ifdef AGC_FREEZE_EN
        // Freeze: low levels must not move the gain; release resumes stepping.
        set_window(64'd1000, 64'd50);
        agc_freeze = 1'b1;
        m_settle = 0; m_lock_cnt = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            level_in = W_LVL'(64'd10);
            level_valid = 1'b1;
            @(negedge clk);
            level_valid = 1'b0;
            repeat (3) @(negedge clk);
            check_loop("frz_hold");
        end
        @(negedge clk);
        agc_freeze = 1'b0;
        pulse(64'd10, "frz_release");
        drain_settle();
`endif

        // Gain increase, settle blanking, second increase, scaled sample
        set_window(64'd1000, 64'd50);
        pulse(64'd200, "inc1");
        for (int k = 0; k < SETTLE_CNT; k++) pulse(64'd200, "inc_settle");
        pulse(64'd200, "inc2");
        drive_iq(100, 7, "inc_iq");
        drain_settle();

        // Lock after LOCK_CNT in-window compares, then loss of lock
        for (int k = 0; k < LOCK_CNT; k++) pulse(64'd1020, "lock");
        pulse(64'd2000, "unlock");
        drain_settle();

        // Floor: step down to 1, then a high level is a no-op with no settle
        while (m_gain > 1) begin
            pulse(64'd5000, "dn");
            drain_settle();
        end
        pulse(64'd5000, "floor");
        pulse(64'd200, "floor_nosettle");
        drain_settle();

        // Randomized loop operation
        for (int it = 0; it < 200; it++) begin
            if ((it % 25 == 0) && (m_settle == 0)) begin
                case ($urandom_range(0, 3))
                    0: set_window(64'($urandom_range(1000, 100000)), 64'($urandom_range(0, 500)));
                    1: set_window(64'd20, 64'd50);
                    2: set_window(LVL_MAX - 64'd10, 64'd100);
                    default: set_window(64'($urandom_range(100, 5000)), 64'd0);
                endcase
            end
            hi = cur_target + cur_hyst;
            lo = (cur_target > cur_hyst) ? cur_target - cur_hyst : 64'd0;
            d  = 64'($urandom_range(1, 1000));
            case ($urandom_range(0, 9))
                0, 1, 2: lvl = lo + (64'($urandom) % (hi - lo + 64'd1));
                3, 4, 5: lvl = (lo >= d) ? lo - d : 64'd0;
                6, 7, 8: lvl = hi + d;
                default: lvl = 64'($urandom);
            endcase
            if (lvl > LVL_MAX) lvl = LVL_MAX;
            if ((m_settle == 0) && ($urandom_range(0, 9) == 0)) double_pulse(lvl, "rnd_dbl");
            else pulse(lvl, "rnd");
            if (it % 10 == 0) drive_iq(int'($urandom_range(0, 65535)), int'($urandom_range(0, 65535)), "rnd_iq");
        end
        drain_settle();

        // Ceiling: ramp to the maximum gain, then saturated no-op skips settle
        set_window(LVL_MAX, 64'd0);
        while (m_gain < GMAX) begin
            pulse(64'd0, "ramp");
            drain_settle();
        end
        pulse(64'd0, "ceil");
        set_window(64'd1000, 64'd0);
        pulse(64'd5000, "ceil_nosettle");
        drive_iq(65535, 65534, "ceil_iq");

        // Asynchronous reset mid-settle
        drain_settle();
        set_window(64'd1000, 64'd0);
        pulse(64'd10, "pre_rst");
        pulse(64'd10, "pre_rst_settle");
        @(negedge clk);
        s_chans_valid = 1'b1;
        @(negedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_eq("mid_rst_gain", 64'(gain_out), 64'd1);
        check_eq("mid_rst_locked", 64'(locked), 64'd0);
        check_eq("mid_rst_mvalid", 64'(m_valid), 64'd0);
        check_eq("mid_rst_mI", 64'(m_dataI), 64'd0);
        s_chans_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        pulse(64'd10, "post_rst");
        drive_iq(321, 123, "post_rst_iq");

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
